// File: rtl/pipeline_feeder.sv
// Issue-side driver for the bot-counting pipeline: assigns collection slots to jobs,
// throttles against the lagging FIFO report and retires each slot's previous result.
module pipeline_feeder #(
  parameter int ADDR_WIDTH   = 9,
  parameter int TAG_WIDTH    = 16,
  parameter int READ_LATENCY = 3,
  parameter int LAG          = 4,
  parameter int FIFO_LIMIT   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jobValid,
  output logic                  jobReady,
  input  logic [127:0]          jobBot,
  input  logic [5:0]            jobPermutations,
  input  logic [TAG_WIDTH-1:0]  jobTag,
  input  logic                  flush,
  output logic                  flushDone,
  output logic [127:0]          bot,
  output logic [ADDR_WIDTH-1:0] botIndex,
  output logic                  isBotValid,
  output logic [5:0]            validBotPermutations,
  input  logic [4:0]            fifoFullness,
  input  logic [37:0]           summedDataOut,
  input  logic [2:0]            pcoeffCountOut,
  output logic                  resultValid,
  output logic [TAG_WIDTH-1:0]  resultTag,
  output logic [37:0]           resultSum,
  output logic [2:0]            resultPcoeffCount
);

  localparam int SLOTS  = 2 ** ADDR_WIDTH;
  localparam int CNT_W  = $clog2(SLOTS + READ_LATENCY + 1);
  localparam int PEND_W = $clog2(6 * LAG + 1);
  localparam int CMP_W  = PEND_W + 3;
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(SLOTS);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SLOTS + READ_LATENCY - 1);
  localparam logic [CMP_W-1:0] LIMIT      = CMP_W'(FIFO_LIMIT);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [2:0]              pend_q [LAG];
  logic [127:0]            bot_q, bot_d;
  logic [ADDR_WIDTH-1:0]   bidx_q, bidx_d;
  logic                    bval_q, bval_d;
  logic [5:0]              vbp_q, vbp_d;
  logic                    done_q, done_d;
  logic                    tok_v_q [READ_LATENCY+1];
  logic [TAG_WIDTH-1:0]    tok_t_q [READ_LATENCY+1];
  logic                    occ_q [SLOTS];
  logic [TAG_WIDTH-1:0]    tag_q [SLOTS];

  logic [2:0]              pop_s;
  logic [PEND_W-1:0]       pending_s;
  logic [CMP_W-1:0]        fill_s;
  logic                    ready_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   walk_slot_s;
  logic                    launch_s;
  logic [TAG_WIDTH-1:0]    launch_tag_s;
  logic                    occ_we_s;
  logic [ADDR_WIDTH-1:0]   occ_wa_s;
  logic                    occ_wd_s;
  logic                    tag_we_s;

  // Projected FIFO occupancy: lagging report plus work issued inside the lag window.
  always_comb begin
    pop_s     = popcount6(jobPermutations);
    pending_s = {PEND_W{1'b0}};
    for (int i = 0; i < LAG; i++) begin
      pending_s = pending_s + PEND_W'(pend_q[i]);
    end
    fill_s   = CMP_W'(fifoFullness) + CMP_W'(pending_s) + CMP_W'(pop_s);
    ready_s  = (state_q == ST_RUN) && (fill_s <= LIMIT);
    accept_s = jobValid && ready_s;
  end

  assign walk_slot_s = idx_q + cnt_q[ADDR_WIDTH-1:0];

  // Next-state, slot bookkeeping and pipeline-port decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    bot_d        = bot_q;
    bidx_d       = idx_q;
    bval_d       = 1'b0;
    vbp_d        = 6'd0;
    done_d       = 1'b0;
    launch_s     = 1'b0;
    launch_tag_s = {TAG_WIDTH{1'b0}};
    occ_we_s     = 1'b0;
    occ_wa_s     = idx_q;
    occ_wd_s     = 1'b0;
    tag_we_s     = 1'b0;
    case (state_q)
      ST_INIT: begin
        occ_we_s = 1'b1;
        occ_wa_s = cnt_q[ADDR_WIDTH-1:0];
        if (cnt_q == WALK_LAST) begin
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          bot_d        = jobBot;
          vbp_d        = jobPermutations;
          bval_d       = 1'b1;
          launch_s     = occ_q[idx_q];
          launch_tag_s = tag_q[idx_q];
          occ_we_s     = 1'b1;
          occ_wd_s     = 1'b1;
          tag_we_s     = 1'b1;
          idx_d        = idx_q + ADDR_WIDTH'(1);
        end else begin
          bval_d = 1'b0;
        end
        // A same-cycle accept has already advanced idx, so the walk starts after it.
        if (flush) begin
          state_d = ST_FLUSH;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (cnt_q < WALK_END) begin
          bidx_d       = walk_slot_s;
          launch_s     = occ_q[walk_slot_s];
          launch_tag_s = tag_q[walk_slot_s];
          occ_we_s     = 1'b1;
          occ_wa_s     = walk_slot_s;
        end else begin
          bidx_d = idx_q;
        end
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, throttle window, registered pipeline outputs and retire delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {ADDR_WIDTH{1'b0}};
      bot_q   <= 128'd0;
      bidx_q  <= {ADDR_WIDTH{1'b0}};
      bval_q  <= 1'b0;
      vbp_q   <= 6'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < LAG; i++) begin
        pend_q[i] <= 3'd0;
      end
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tok_v_q[i] <= 1'b0;
        tok_t_q[i] <= {TAG_WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bot_q   <= bot_d;
      bidx_q  <= bidx_d;
      bval_q  <= bval_d;
      vbp_q   <= vbp_d;
      done_q  <= done_d;
      pend_q[0] <= accept_s ? pop_s : 3'd0;
      for (int i = 1; i < LAG; i++) begin
        pend_q[i] <= pend_q[i-1];
      end
      tok_v_q[0] <= launch_s;
      tok_t_q[0] <= launch_tag_s;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tok_v_q[i] <= tok_v_q[i-1];
        tok_t_q[i] <= tok_t_q[i-1];
      end
    end
  end

  // Slot RAMs carry no reset; occupancy is cleared by the post-reset walk.
  always_ff @(posedge clk) begin
    if (occ_we_s) begin
      occ_q[occ_wa_s] <= occ_wd_s;
    end
    if (tag_we_s) begin
      tag_q[idx_q] <= jobTag;
    end
  end

  assign jobReady             = ready_s;
  assign flushDone            = done_q;
  assign bot                  = bot_q;
  assign botIndex             = bidx_q;
  assign isBotValid           = bval_q;
  assign validBotPermutations = vbp_q;
  assign resultValid          = tok_v_q[READ_LATENCY];
  assign resultTag            = tok_t_q[READ_LATENCY];
  // Collector data is valid in the retire cycle itself, so it is forwarded, not re-registered.
  assign resultSum            = tok_v_q[READ_LATENCY] ? summedDataOut : 38'd0;
  assign resultPcoeffCount    = tok_v_q[READ_LATENCY] ? pcoeffCountOut : 3'd0;

endmodule

// File: tb/tb_pipeline_feeder.sv
// Scoreboard bench for pipeline_feeder with a small slot-collector model standing in
// for the pipeline (read data returned three cycles after botIndex).
module tb_pipeline_feeder;

  localparam int AW = 4;
  localparam int N  = 16;
  localparam int TW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           jobValid = 1'b0;
  logic           jobReady;
  logic [127:0]   jobBot = 128'd0;
  logic [5:0]     jobPermutations = 6'd0;
  logic [TW-1:0]  jobTag = 16'd0;
  logic           flush = 1'b0;
  logic           flushDone;
  logic [127:0]   bot;
  logic [AW-1:0]  botIndex;
  logic           isBotValid;
  logic [5:0]     validBotPermutations;
  logic [4:0]     fifoFullness = 5'd0;
  logic [37:0]    summedDataOut;
  logic [2:0]     pcoeffCountOut;
  logic           resultValid;
  logic [TW-1:0]  resultTag;
  logic [37:0]    resultSum;
  logic [2:0]     resultPcoeffCount;

  always #5 clk = ~clk;

  pipeline_feeder #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .jobValid(jobValid), .jobReady(jobReady), .jobBot(jobBot),
    .jobPermutations(jobPermutations), .jobTag(jobTag), .flush(flush), .flushDone(flushDone),
    .bot(bot), .botIndex(botIndex), .isBotValid(isBotValid),
    .validBotPermutations(validBotPermutations), .fifoFullness(fifoFullness),
    .summedDataOut(summedDataOut), .pcoeffCountOut(pcoeffCountOut),
    .resultValid(resultValid), .resultTag(resultTag), .resultSum(resultSum),
    .resultPcoeffCount(resultPcoeffCount)
  );

  int n_vec = 0;
  int n_err = 0;
  int ec = 0;
  int results_seen = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [37:0]   sum;
    logic [2:0]    pc;
    int            at;
  } exp_t;
  exp_t sb[$];

  int            idx_m;
  logic          occ_m [N];
  logic [TW-1:0] tag_m [N];
  logic [37:0]   sum_m [N];
  logic [2:0]    pc_m  [N];

  function automatic logic [37:0] fsum(input logic [127:0] b, input logic [5:0] m);
    return (m == 6'd0) ? 38'd0 : {6'd0, b[31:0]};
  endfunction

  function automatic logic [2:0] fpc(input logic [127:0] b, input logic [5:0] m);
    return (m == 6'd0) ? 3'd0 : b[34:32];
  endfunction

  function automatic logic [127:0] mkbot(input int i);
    logic [127:0] b;
    b = 128'd0;
    b[31:0]   = 32'(i * 16 + 5);
    b[34:32]  = 3'(i);
    b[127:96] = 32'(32'hB0B0_0000 + i);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ec);
    end
  endtask

  // Edge counter used to timestamp expected retires
  always @(posedge clk) ec <= ec + 1;

  // Collector model: read-before-write per slot, data returned three cycles after botIndex
  logic [40:0] cmem [N];
  logic [40:0] rd0, rd1, rd2;
  always @(posedge clk) begin
    rd0 <= cmem[botIndex];
    rd1 <= rd0;
    rd2 <= rd1;
    if (isBotValid) cmem[botIndex] <= {fpc(bot, validBotPermutations), fsum(bot, validBotPermutations)};
  end
  assign summedDataOut  = rd2[37:0];
  assign pcoeffCountOut = rd2[40:38];

  // Result monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst && resultValid) begin
      results_seen++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: tag %0h sum %0h with empty scoreboard", resultTag, resultSum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_tag", 64'(resultTag), 64'(e.tag));
        chk("res_sum", 64'(resultSum), 64'(e.sum));
        chk("res_pcoeff", 64'(resultPcoeffCount), 64'(e.pc));
        chk("res_edge", 64'(ec), 64'(e.at));
      end
    end
  end

  task automatic apply_reset();
    int n;
    rst = 1'b0;
    jobValid = 1'b0;
    flush = 1'b0;
    jobPermutations = 6'd0;
    fifoFullness = 5'd0;
    sb.delete();
    idx_m = 0;
    for (int i = 0; i < N; i++) occ_m[i] = 1'b0;
    #1;
    chk("reset_ctrl", 64'({jobReady, flushDone, isBotValid, resultValid}), 64'd0);
    chk("reset_bot_lo", bot[63:0], 64'd0);
    chk("reset_bot_hi", bot[127:64], 64'd0);
    chk("reset_idx_vbp", 64'({botIndex, validBotPermutations}), 64'd0);
    chk("reset_result", 64'({resultTag, resultSum, resultPcoeffCount}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (jobReady) break;
      n++;
    end
    chk("walk_cycles", 64'(n), 64'd15);
  endtask

  task automatic issue(input logic [TW-1:0] tag, input logic [5:0] mask, input logic [127:0] b,
                       output int stalls);
    int   slot;
    exp_t e;
    jobValid = 1'b1;
    jobTag = tag;
    jobPermutations = mask;
    jobBot = b;
    #1;
    stalls = 0;
    while (!jobReady && stalls < 64) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!jobReady) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: tag %0h never accepted, jobReady %0b required 1", tag, jobReady);
      jobValid = 1'b0;
      return;
    end
    slot = idx_m;
    if (occ_m[slot]) begin
      e.tag = tag_m[slot];
      e.sum = sum_m[slot];
      e.pc  = pc_m[slot];
      e.at  = ec + 4;
      sb.push_back(e);
    end
    occ_m[slot] = 1'b1;
    tag_m[slot] = tag;
    sum_m[slot] = fsum(b, mask);
    pc_m[slot]  = fpc(b, mask);
    idx_m = (idx_m + 1) % N;
    @(negedge clk);
    chk("issue_valid", 64'(isBotValid), 64'd1);
    chk("issue_index", 64'(botIndex), 64'(slot));
    chk("issue_mask", 64'(validBotPermutations), 64'(mask));
    chk("issue_bot_lo", bot[63:0], b[63:0]);
    chk("issue_bot_hi", bot[127:64], b[127:64]);
  endtask

  task automatic idle(input int n);
    jobValid = 1'b0;
    jobPermutations = 6'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_flush();
    int   ec0;
    int   slot;
    logic rdy_seen;
    exp_t e;
    jobValid = 1'b0;
    jobPermutations = 6'd0;
    flush = 1'b1;
    ec0 = ec;
    for (int k = 0; k < N; k++) begin
      slot = (idx_m + k) % N;
      if (occ_m[slot]) begin
        e.tag = tag_m[slot];
        e.sum = sum_m[slot];
        e.pc  = pc_m[slot];
        e.at  = ec0 + k + 5;
        sb.push_back(e);
        occ_m[slot] = 1'b0;
      end
    end
    @(negedge clk);
    flush = 1'b0;
    jobValid = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (flushDone) break;
      rdy_seen = rdy_seen | jobReady;
      @(negedge clk);
    end
    jobValid = 1'b0;
    if (!flushDone) begin
      n_vec++;
      n_err++;
      $display("FAIL flush_timeout: flushDone %0b required 1 within 40 cycles", flushDone);
    end else begin
      chk("flush_done_edge", 64'(ec), 64'(ec0 + N + 4));
    end
    chk("flush_ready_low", 64'(rdy_seen), 64'd0);
    @(negedge clk);
    chk("flush_done_pulse", 64'(flushDone), 64'd0);
    chk("flush_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int s;
    int base;
    #2;
    apply_reset();

    // Issue 17 jobs: first three back-to-back on slots 0..2, 17th wraps to slot 0
    for (int i = 0; i < 17; i++) begin
      issue(16'(16'h00A0 + i), 6'b111111, mkbot(i), s);
      if (i < 3) chk("basic_no_stall", 64'(s), 64'd0);
    end

    // Throttle: 20 + 0 + 2 and 20 + 2 + 2 fit, third waits for the window to slide
    idle(5);
    fifoFullness = 5'd20;
    issue(16'h00C0, 6'b000011, mkbot(40), s);
    chk("throttle_job0_stall", 64'(s), 64'd0);
    issue(16'h00C1, 6'b000011, mkbot(41), s);
    chk("throttle_job1_stall", 64'(s), 64'd0);
    issue(16'h00C2, 6'b000011, mkbot(42), s);
    chk("throttle_job2_stall", 64'(s), 64'd3);
    fifoFullness = 5'd0;

    // Zero-permutation job still takes a slot; its flushed result is zero
    issue(16'h00D0, 6'b000000, mkbot(50), s);
    idle(1);
    do_flush();

    // Fresh slots: five jobs then flush retires exactly slots 0..4 in order
    apply_reset();
    for (int i = 0; i < 5; i++) issue(16'(16'h00F0 + i), 6'b111111, mkbot(60 + i), s);
    idle(1);
    do_flush();

    // Reset in the middle of a flush walk drops every in-flight result
    for (int i = 0; i < 3; i++) issue(16'(16'h0E00 + i), 6'b101010, mkbot(70 + i), s);
    jobValid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    apply_reset();
    base = results_seen;
    idle(20);
    chk("post_reset_results", 64'(results_seen - base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
